// File: rtl/sweep4disp7seg_decode.sv
// ---------------------------------------------------------------------------
// sweep4disp7seg_decode
//
// Receiving end of a 4-digit multiplexed 7-segment display bus. The segment
// and digit-select buses are sampled, filtered for stability, and decoded
// back into the four 5-bit digit codes that the sweep driver is showing.
// A digit is only committed after STABLE_CYCLES identical samples, so the
// ghosting seen while the driver switches digits is never captured.
//
// Optional feature: define DP_DECODE_EN to decode the decimal point (seg[7])
// separately into dpOut instead of treating it as part of the pattern.
//
// Ports:
//   clk         system clock
//   rst         asynchronous reset, active low
//   seg[7:0]    segment bus, active low (bit7 = dp, bits6..0 = g..a)
//   dispTrans   digit select, active low, one-hot-low when a digit is lit
//   disp0..3    reconstructed 5-bit digit codes
//   digitValid  bit i set when dispi holds a fresh committed code
//   frameDone   one-cycle pulse once all four digits have been committed
//   stale       set after a commit timeout, cleared by the next commit
//   badPattern  sticky: an unknown segment pattern was committed
//   badAnode    sticky: more than one dispTrans bit was low
//   dpOut       per-digit decimal point (zero unless DP_DECODE_EN)
// ---------------------------------------------------------------------------
module sweep4disp7seg_decode #(
    parameter int STABLE_CYCLES  = 8,
    parameter int NBITS_STABLE   = 4,
    parameter int TIMEOUT_CYCLES = 500_000,
    parameter int NBITS_TIMEOUT  = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] seg,
    input  logic [3:0] dispTrans,
    output logic [4:0] disp0,
    output logic [4:0] disp1,
    output logic [4:0] disp2,
    output logic [4:0] disp3,
    output logic [3:0] digitValid,
    output logic       frameDone,
    output logic       stale,
    output logic       badPattern,
    output logic       badAnode,
    output logic [3:0] dpOut
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_LOCKED
    } state_t;

    localparam logic [NBITS_STABLE-1:0]  STABLE_LIM = NBITS_STABLE'(STABLE_CYCLES);
    localparam logic [NBITS_STABLE-1:0]  STABLE_ONE = NBITS_STABLE'(1);
    localparam logic [NBITS_TIMEOUT-1:0] TO_LIM     = NBITS_TIMEOUT'(TIMEOUT_CYCLES);
    localparam logic [NBITS_TIMEOUT-1:0] TO_LIM_M1  = NBITS_TIMEOUT'(TIMEOUT_CYCLES - 1);
    localparam logic [NBITS_TIMEOUT-1:0] TO_ONE     = NBITS_TIMEOUT'(1);

    // Segment pattern to digit code; anything not in the table is 31.
    function automatic logic [4:0] decode_seg(input logic [7:0] pat);
        logic [4:0] code;
        case (pat)
            8'hC0:   code = 5'd0;
            8'hF9:   code = 5'd1;
            8'hA4:   code = 5'd2;
            8'hB0:   code = 5'd3;
            8'h99:   code = 5'd4;
            8'h92:   code = 5'd5;
            8'h82:   code = 5'd6;
            8'hF8:   code = 5'd7;
            8'h80:   code = 5'd8;
            8'h90:   code = 5'd9;
            8'h88:   code = 5'd10;
            8'hAB:   code = 5'd11;
            8'hC6:   code = 5'd12;
            8'hC7:   code = 5'd13;
            8'hE3:   code = 5'd14;
            8'h8C:   code = 5'd15;
            8'hFF:   code = 5'd16;
            default: code = 5'd31;
        endcase
        return code;
    endfunction

    // Sampled (S) and previous (P) copies of the input buses.
    logic [7:0]               s_seg_q, p_seg_q;
    logic [3:0]               s_an_q, p_an_q;

    state_t                   state_q, state_d;
    logic [NBITS_STABLE-1:0]  stable_cnt_q, stable_cnt_d;
    logic [NBITS_TIMEOUT-1:0] to_cnt_q, to_cnt_d;
    logic [4:0]               disp_q [4];
    logic [4:0]               disp_d [4];
    logic [3:0]               valid_q, valid_d;
    logic [3:0]               seen_q, seen_d;
    logic                     stale_q, stale_d;
    logic                     bad_pat_q, bad_pat_d;
    logic                     bad_an_q, bad_an_d;

    logic                     an_valid, an_illegal;
    logic [1:0]               an_idx;
    logic                     same;
    logic                     commit;
    logic                     timeout_hit;
    logic [7:0]               lookup;
    logic [4:0]               code;
    logic [NBITS_STABLE-1:0]  stable_inc;

    // Input stage: every decision below works from the registered copy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s_seg_q <= 8'hFF;
            p_seg_q <= 8'hFF;
            s_an_q  <= 4'hF;
            p_an_q  <= 4'hF;
        end else begin
            s_seg_q <= seg;
            p_seg_q <= s_seg_q;
            s_an_q  <= dispTrans;
            p_an_q  <= s_an_q;
        end
    end

    // Anode classification: one low bit is a lit digit, all high is idle,
    // anything else is an illegal overlap that is handled like idle.
    always_comb begin
        an_valid   = 1'b0;
        an_illegal = 1'b0;
        an_idx     = 2'd0;
        case (s_an_q)
            4'b1110: begin an_valid = 1'b1; an_idx = 2'd0; end
            4'b1101: begin an_valid = 1'b1; an_idx = 2'd1; end
            4'b1011: begin an_valid = 1'b1; an_idx = 2'd2; end
            4'b0111: begin an_valid = 1'b1; an_idx = 2'd3; end
            4'b1111: an_illegal = 1'b0;
            default: an_illegal = 1'b1;
        endcase
    end

    assign same       = (s_seg_q == p_seg_q) && (s_an_q == p_an_q);
    assign stable_inc = stable_cnt_q + STABLE_ONE;

`ifdef DP_DECODE_EN
    assign lookup = s_seg_q | 8'h80;
`else
    assign lookup = s_seg_q;
`endif
    assign code = decode_seg(lookup);

    // Stability FSM. The commit fires in the same cycle the count reaches
    // STABLE_CYCLES; LOCKED then blocks repeated commits of the same digit.
    always_comb begin
        state_d      = state_q;
        stable_cnt_d = stable_cnt_q;
        commit       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (an_valid) begin
                    state_d      = ST_SETTLE;
                    stable_cnt_d = STABLE_ONE;
                end else begin
                    stable_cnt_d = '0;
                end
            end
            ST_SETTLE: begin
                if (!an_valid) begin
                    state_d      = ST_IDLE;
                    stable_cnt_d = '0;
                end else if (!same) begin
                    stable_cnt_d = STABLE_ONE;
                end else begin
                    stable_cnt_d = stable_inc;
                    if (stable_inc == STABLE_LIM) begin
                        commit  = 1'b1;
                        state_d = ST_LOCKED;
                    end
                end
            end
            ST_LOCKED: begin
                if (!same) begin
                    if (an_valid) begin
                        state_d      = ST_SETTLE;
                        stable_cnt_d = STABLE_ONE;
                    end else begin
                        state_d      = ST_IDLE;
                        stable_cnt_d = '0;
                    end
                end
            end
            default: begin
                state_d      = ST_IDLE;
                stable_cnt_d = '0;
            end
        endcase
    end

    // Commit, frame tracking and timeout. A commit always wins over a
    // timeout in the same cycle, and a commit landing while seen is being
    // cleared for the frame pulse keeps its own seen bit.
    always_comb begin
        disp_d    = disp_q;
        valid_d   = valid_q;
        stale_d   = stale_q;
        bad_pat_d = bad_pat_q | (commit && (code == 5'd31));
        bad_an_d  = bad_an_q | an_illegal;

        timeout_hit = !commit && (to_cnt_q >= TO_LIM_M1);

        if (commit) begin
            to_cnt_d = '0;
        end else if (to_cnt_q != TO_LIM) begin
            to_cnt_d = to_cnt_q + TO_ONE;
        end else begin
            to_cnt_d = to_cnt_q;
        end

        seen_d = (seen_q == 4'hF) ? 4'h0 : seen_q;
        if (timeout_hit) begin
            seen_d  = 4'h0;
            valid_d = 4'h0;
            stale_d = 1'b1;
        end
        if (commit) begin
            disp_d[an_idx]  = code;
            valid_d[an_idx] = 1'b1;
            seen_d[an_idx]  = 1'b1;
            stale_d         = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            stable_cnt_q <= '0;
            to_cnt_q     <= '0;
            disp_q       <= '{default: 5'd0};
            valid_q      <= 4'h0;
            seen_q       <= 4'h0;
            stale_q      <= 1'b0;
            bad_pat_q    <= 1'b0;
            bad_an_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            stable_cnt_q <= stable_cnt_d;
            to_cnt_q     <= to_cnt_d;
            disp_q       <= disp_d;
            valid_q      <= valid_d;
            seen_q       <= seen_d;
            stale_q      <= stale_d;
            bad_pat_q    <= bad_pat_d;
            bad_an_q     <= bad_an_d;
        end
    end

`ifdef DP_DECODE_EN
    logic [3:0] dp_q, dp_d;

    // Decimal point is active low on the bus; capture it with the digit.
    always_comb begin
        dp_d = dp_q;
        if (commit) begin
            dp_d[an_idx] = ~s_seg_q[7];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dp_q <= 4'h0;
        end else begin
            dp_q <= dp_d;
        end
    end

    assign dpOut = dp_q;
`else
    assign dpOut = 4'h0;
`endif

    assign disp0      = disp_q[0];
    assign disp1      = disp_q[1];
    assign disp2      = disp_q[2];
    assign disp3      = disp_q[3];
    assign digitValid = valid_q;
    assign frameDone  = (seen_q == 4'hF);
    assign stale      = stale_q;
    assign badPattern = bad_pat_q;
    assign badAnode   = bad_an_q;

endmodule

// File: tb/tb_sweep4disp7seg_decode.sv
// ---------------------------------------------------------------------------
// tb_sweep4disp7seg_decode
//
// Directed bench for the 7-segment bus decoder. Expected digit commits are
// queued when a pattern is driven and popped when the commit is due.
// The timeout is shortened so the stale path is reachable quickly.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sweep4disp7seg_decode;

    localparam int TO_CYCLES = 300;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] seg;
    logic [3:0] dispTrans;
    logic [4:0] disp0, disp1, disp2, disp3;
    logic [3:0] digitValid;
    logic       frameDone;
    logic       stale;
    logic       badPattern;
    logic       badAnode;
    logic [3:0] dpOut;

    sweep4disp7seg_decode #(
        .STABLE_CYCLES  (8),
        .NBITS_STABLE   (4),
        .TIMEOUT_CYCLES (TO_CYCLES),
        .NBITS_TIMEOUT  (20)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .seg        (seg),
        .dispTrans  (dispTrans),
        .disp0      (disp0),
        .disp1      (disp1),
        .disp2      (disp2),
        .disp3      (disp3),
        .digitValid (digitValid),
        .frameDone  (frameDone),
        .stale      (stale),
        .badPattern (badPattern),
        .badAnode   (badAnode),
        .dpOut      (dpOut)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         idx;
        logic [4:0] code;
        logic       dp;
    } commit_t;

    commit_t expQ[$];
    int      checks = 0;
    int      errors = 0;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Advance n rising edges and settle just after the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0] an, input logic [7:0] sg);
        @(negedge clk);
        dispTrans = an;
        seg       = sg;
    endtask

    task automatic expectCommit(input int idx, input logic [4:0] code, input logic dp);
        commit_t e;
        e.idx  = idx;
        e.code = code;
        e.dp   = dp;
        expQ.push_back(e);
    endtask

    function automatic logic [4:0] dispOf(input int idx);
        case (idx)
            0:       return disp0;
            1:       return disp1;
            2:       return disp2;
            default: return disp3;
        endcase
    endfunction

    task automatic checkCommit(input string tag);
        commit_t e;
        if (expQ.size() == 0) begin
            checks++;
            errors++;
            $error("[TB] FAIL %s: observed=no_expectation expected=queued_commit", tag);
        end else begin
            e = expQ.pop_front();
            checkOutput({tag, "_disp"}, 32'(dispOf(e.idx)), 32'(e.code));
            checkOutput({tag, "_valid"}, 32'(digitValid[e.idx]), 32'd1);
            checkOutput({tag, "_dp"}, 32'(dpOut[e.idx]), 32'(e.dp));
        end
    endtask

    logic [7:0] sweepSeg  [4] = '{8'hB0, 8'h88, 8'h8C, 8'hFF};
    logic [4:0] sweepCode [4] = '{5'd3, 5'd10, 5'd15, 5'd16};
    logic [4:0] code12;
    logic       dp12;
    logic [4:0] code40;
    logic       dp40;
    logic       expBadPattern;

    initial begin
`ifdef DP_DECODE_EN
        code12 = 5'd5;  dp12 = 1'b1;
        code40 = 5'd0;  dp40 = 1'b1;
`else
        code12 = 5'd31; dp12 = 1'b0;
        code40 = 5'd31; dp40 = 1'b0;
`endif

        // Reset state
        rst       = 1'b0;
        seg       = 8'hFF;
        dispTrans = 4'hF;
        tick(3);
        checkOutput("rst_disp", 32'({disp3, disp2, disp1, disp0}), 32'd0);
        checkOutput("rst_valid", 32'(digitValid), 32'd0);
        checkOutput("rst_flags", 32'({frameDone, stale, badPattern, badAnode}), 32'd0);
        checkOutput("rst_dp", 32'(dpOut), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        tick(2);

        // Single digit: exact commit latency, no second commit
        applyStimulus(4'b1110, 8'hA4);
        expectCommit(0, 5'd2, 1'b0);
        tick(8);
        checkOutput("lat_early_valid", 32'(digitValid), 32'd0);
        tick(1);
        checkCommit("lat_commit");
        checkOutput("lat_valid_vec", 32'(digitValid), 32'h1);
        tick(11);
        checkOutput("hold_disp0", 32'(disp0), 32'd2);
        checkOutput("hold_valid", 32'(digitValid), 32'h1);
        checkOutput("hold_frame", 32'(frameDone), 32'd0);

        // Sweep all four digits; frame pulse after the last one
        for (int i = 0; i < 4; i++) begin
            applyStimulus(~(4'b0001 << i), sweepSeg[i]);
            expectCommit(i, sweepCode[i], 1'b0);
            tick(8);
            checkOutput("sweep_pre_frame", 32'(frameDone), 32'd0);
            tick(1);
            checkCommit("sweep");
            checkOutput("sweep_frame", 32'(frameDone), (i == 3) ? 32'd1 : 32'd0);
            tick(1);
            checkOutput("sweep_frame_end", 32'(frameDone), 32'd0);
            tick(10);
        end
        checkOutput("sweep_all", 32'({disp3, disp2, disp1, disp0}),
                    32'({5'd16, 5'd15, 5'd10, 5'd3}));
        checkOutput("sweep_no_repulse", 32'(frameDone), 32'd0);

        // Reset in the middle of a settle
        applyStimulus(4'b1101, 8'hF9);
        tick(4);
        @(negedge clk);
        rst       = 1'b0;
        seg       = 8'hFF;
        dispTrans = 4'hF;
        #1;
        checkOutput("midrst_valid", 32'(digitValid), 32'd0);
        checkOutput("midrst_disp", 32'({disp3, disp2, disp1, disp0}), 32'd0);
        tick(2);
        @(negedge clk);
        rst = 1'b1;
        tick(2);
        checkOutput("midrst_after", 32'(digitValid), 32'd0);

        // Toggling faster than the filter never commits
        for (int k = 0; k < 5; k++) begin
            applyStimulus(4'b1101, (k % 2 == 0) ? 8'hC0 : 8'hF9);
            tick(4);
        end
        checkOutput("toggle_valid", 32'(digitValid), 32'd0);
        applyStimulus(4'b1101, 8'hF9);
        expectCommit(1, 5'd1, 1'b0);
        tick(8);
        checkOutput("toggle_hold_early", 32'(digitValid[1]), 32'd0);
        tick(1);
        checkCommit("toggle_hold");

        // Illegal anode for one cycle, then a bad pattern on digit 2
        applyStimulus(4'b1100, 8'hFF);
        applyStimulus(4'b1011, 8'h12);
        expectCommit(2, code12, dp12);
        tick(8);
        checkOutput("badan_set", 32'(badAnode), 32'd1);
        checkOutput("badpat_before", 32'(badPattern), 32'd0);
        checkOutput("badpat_valid2", 32'(digitValid[2]), 32'd0);
        tick(1);
        checkCommit("badpat");
        expBadPattern = (code12 == 5'd31);
        checkOutput("badpat_flag", 32'(badPattern), 32'(expBadPattern));

        // Idle bus until the timeout
        applyStimulus(4'b1111, 8'hFF);
        tick(290);
        checkOutput("to_early_stale", 32'(stale), 32'd0);
        checkOutput("to_early_valid", 32'(digitValid), 32'h6);
        tick(20);
        checkOutput("to_stale", 32'(stale), 32'd1);
        checkOutput("to_valid", 32'(digitValid), 32'd0);
        checkOutput("to_disp_held", 32'({disp2, disp1}), 32'({code12, 5'd1}));
        checkOutput("to_badan_sticky", 32'(badAnode), 32'd1);
        applyStimulus(4'b1110, 8'hA4);
        expectCommit(0, 5'd2, 1'b0);
        tick(8);
        checkOutput("to_stale_hold", 32'(stale), 32'd1);
        tick(1);
        checkCommit("to_recommit");
        checkOutput("to_stale_clear", 32'(stale), 32'd0);
        checkOutput("to_valid_after", 32'(digitValid), 32'h1);

        // Decimal point pattern on digit 3
        applyStimulus(4'b0111, 8'h40);
        expectCommit(3, code40, dp40);
        tick(9);
        checkCommit("dp");
        expBadPattern = expBadPattern | (code40 == 5'd31);
        checkOutput("dp_badpat", 32'(badPattern), 32'(expBadPattern));

        tick(3);
        checkOutput("scoreboard_empty", 32'(expQ.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
